// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC result conversion path.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          BIAS    = 127;
  localparam int          MANT_W  = 23;
  localparam int          EXP_W   = 8;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even and IEEE-754 single packing of a
// normalised 32-bit significand (hidden one in bit 31).
module fp_round_pack
  import cordic_pkg::*;
(
  input  logic [31:0] i_shreg,
  input  logic [8:0]  i_exp,
  output logic [31:0] o_float
);

  logic [MANT_W-1:0] w_mant;
  logic              w_guard;
  logic              w_sticky;
  logic              w_rnd_up;
  logic [MANT_W:0]   w_mant_sum;
  logic [8:0]        w_exp_sum;
  logic              w_unused_exp_msb;

  // Round half to even, then fold a mantissa carry-out into the exponent;
  // on carry-out the low MANT_W bits of the sum are already zero.
  always_comb begin
    w_mant     = i_shreg[30:8];
    w_guard    = i_shreg[7];
    w_sticky   = |i_shreg[6:0];
    w_rnd_up   = w_guard & (w_sticky | w_mant[0]);
    w_mant_sum = {1'b0, w_mant} + {{MANT_W{1'b0}}, w_rnd_up};
    w_exp_sum  = i_exp + {8'd0, w_mant_sum[MANT_W]};
    o_float    = {1'b0, w_exp_sum[EXP_W-1:0], w_mant_sum[MANT_W-1:0]};
  end

  // Exponent never exceeds 8 bits for the supported operand range.
  assign w_unused_exp_msb = w_exp_sum[8];

endmodule

// File: rtl/fixq_to_float.sv
// Multi-cycle custom instruction: unsigned fixed-point (FRAC_BITS fraction
// bits) to IEEE-754 single. Normalises one bit per cycle, then rounds.
module fixq_to_float #(
  parameter int FRAC_BITS = 30,
  parameter int BIAS      = cordic_pkg::BIAS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
);

  // Exponent of the value with the hidden one at bit 31 and no shifts yet.
  localparam logic [8:0] EXP_BASE = 9'(31 - FRAC_BITS + BIAS);

  cordic_pkg::state_t r_state;
  cordic_pkg::state_t w_state_nxt;
  logic [31:0]        r_shreg;
  logic [5:0]         r_lz;
  logic [31:0]        r_result;
  logic [8:0]         w_exp;
  logic [31:0]        w_packed;

  assign w_exp = EXP_BASE - {3'd0, r_lz};

  fp_round_pack u_round_pack (
    .i_shreg (r_shreg),
    .i_exp   (w_exp),
    .o_float (w_packed)
  );

  // Next-state logic: zero short-cuts to DONE, otherwise shift until bit 31 is set.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      cordic_pkg::IDLE: begin
        if (start) w_state_nxt = cordic_pkg::SHIFT;
      end
      cordic_pkg::SHIFT: begin
        if (r_shreg == 32'd0)  w_state_nxt = cordic_pkg::DONE;
        else if (r_shreg[31])  w_state_nxt = cordic_pkg::ROUND;
      end
      cordic_pkg::ROUND: w_state_nxt = cordic_pkg::DONE;
      cordic_pkg::DONE:  w_state_nxt = cordic_pkg::IDLE;
      default:           w_state_nxt = cordic_pkg::IDLE;
    endcase
  end

  // State register; clk_en freezes the whole block.
  always_ff @(posedge clk) begin
    if (reset)       r_state <= cordic_pkg::IDLE;
    else if (clk_en) r_state <= w_state_nxt;
  end

  // Operand capture, serial normalisation and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg  <= 32'd0;
      r_lz     <= 6'd0;
      r_result <= cordic_pkg::FP_ZERO;
    end else if (clk_en) begin
      case (r_state)
        cordic_pkg::IDLE: begin
          if (start) begin
            r_shreg <= dataa;
            r_lz    <= 6'd0;
          end
        end
        cordic_pkg::SHIFT: begin
          if (r_shreg == 32'd0) begin
            r_result <= cordic_pkg::FP_ZERO;
          end else if (!r_shreg[31]) begin
            r_shreg <= {r_shreg[30:0], 1'b0};
            r_lz    <= r_lz + 6'd1;
          end
        end
        cordic_pkg::ROUND: r_result <= w_packed;
        default: ;
      endcase
    end
  end

  assign done   = (r_state == cordic_pkg::DONE);
  assign result = r_result;

endmodule
